gcn_sched_ctrl: RTL and testbench
=================================

Name: gcn_sched_ctrl

Overview:
Top-level sequencer for the GCN inference datapath. It runs one inference per start pulse in this order: COO edge load, weight-row fetch, feature-column fetch, transform, aggregate, argmax, result drain. Fetches and the drain use request/grant handshakes; the three compute phases use a start pulse and a done handshake, each guarded by a watchdog. It also reports busy/done/error status and a per-run cycle count.

Parameters:
NUM_NODES, 6, graph nodes = result rows drained
NUM_CLASSES, 3, weight rows fetched
NUM_FEAT, 96, feature columns fetched
TIMEOUT_CYC, 64, max cycles to wait for a compute-phase done

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  run request, sampled only in IDLE
abort  in  1  synchronous abort
coo_load_en  out  1  one-cycle pulse: COO decoder captures edge list
wm_rd_en  out  1  weight-row read request
wm_rd_addr  out  2  weight row index
wm_rd_gnt  in  1  weight read accepted
fm_rd_en  out  1  feature-column read request
fm_rd_addr  out  7  feature column index
fm_rd_gnt  in  1  feature read accepted
trans_start / agg_start / amax_start  out  1 each  one-cycle phase kick
trans_done / agg_done / amax_done  in  1 each  phase complete
out_valid  out  1  result address valid
out_addr  out  3  node index being drained
out_ready  in  1  result sink accepts
busy  out  1  high in every non-IDLE state
done  out  1  one-cycle pulse on successful completion
err  out  1  one-cycle pulse on watchdog expiry
cyc_cnt  out  16  cycles spent in the last/current run

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0; address counters, watchdog and cyc_cnt cleared.
- States: IDLE, LD_COO, LD_W, LD_F, XFORM, AGG, AMAX, DRAIN, FIN. All transitions are registered.
- IDLE: start=1 -> LD_COO. On the accepting cycle cyc_cnt clears. start is ignored in all other states.
- LD_COO: coo_load_en=1 for exactly this one cycle -> LD_W.
- LD_W: wm_rd_en=1 with wm_rd_addr held stable until wm_rd_gnt. Each gnt increments the address. Gnt on address NUM_CLASSES-1 -> LD_F with the address reset to 0.
- LD_F: same rule with fm_rd_en/fm_rd_addr/fm_rd_gnt over 0..NUM_FEAT-1 -> XFORM.
- XFORM/AGG/AMAX: the matching *_start is 1 only in the entry cycle. The done input is ignored in that entry cycle and sampled from the next cycle on. done=1 -> next phase (XFORM->AGG->AMAX->DRAIN).
- Watchdog: clears on entry to each compute state and increments every cycle in it. If it reaches TIMEOUT_CYC without done: err=1 for one cycle, go to IDLE, no done pulse. A done arriving in the same cycle as expiry wins, and no err is raised.
- DRAIN: out_valid=1 with out_addr held until out_ready. The address increments on each accept. Accept of NUM_NODES-1 -> FIN.
- FIN: done=1 for one cycle -> IDLE.
- busy = (state != IDLE). Never asserted together with done's following IDLE cycle.
- cyc_cnt: increments every non-IDLE cycle, saturates at 16'hFFFF, and holds its value in IDLE until the next accepted start.
- abort=1 in any non-IDLE state: IDLE next cycle, all requests/strobes deasserted, no done/err, cyc_cnt holds. abort has priority over every other transition. abort in IDLE is a no-op, even with start=1 (start is not accepted).
- Async reset mid-run: immediate return to IDLE with reset values. No pulse is emitted.
- Minimum latency, with all gnt/ready tied to 1 and each done one cycle after its start: done at cycle 2+NUM_CLASSES+NUM_FEAT+6+NUM_NODES after the start cycle, i.e. 113 with defaults. cyc_cnt=113.

Test Plan:
- Nominal: start at cycle 0, gnt/ready tied 1, dones 1 cycle after starts -> wm addr 0,1,2 at cycles 2-4; fm addr 0..95 at cycles 5-100; trans_start @101; out_addr 0..5 at cycles 107-112; done @113; cyc_cnt=113.
- Backpressure: wm_rd_gnt low for 3 cycles on addr 1, out_ready toggling 1/0 -> addresses held while ungranted, no skipped/duplicated index, done delayed by exactly the stall cycles.
- Watchdog: agg_done never asserted -> err pulse 64 cycles after the agg_start cycle, then IDLE, busy=0, no done; the next start runs normally.
- Early/coincident done: trans_done=1 in the trans_start cycle and then low -> ignored, FSM stays in XFORM. amax_done at watchdog expiry cycle -> DRAIN, no err.
- Abort: abort during LD_F at fm_rd_addr=40 -> next cycle IDLE, fm_rd_en=0, no done/err. start asserted during busy -> ignored.
- Reset mid-DRAIN (rst_n low at out_addr=3) -> all outputs 0 immediately; after release, start re-runs from LD_COO with out_addr beginning at 0.

Source files
------------

// File: rtl/gcn_sched_ctrl.sv
// GCN inference sequencer: COO load, weight/feature fetch, three watchdog-guarded
// compute phases, and result drain, with run status and cycle count.
module gcn_sched_ctrl #(
  parameter int NUM_NODES   = 6,
  parameter int NUM_CLASSES = 3,
  parameter int NUM_FEAT    = 96,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic        coo_load_en,
  output logic        wm_rd_en,
  output logic [1:0]  wm_rd_addr,
  input  logic        wm_rd_gnt,
  output logic        fm_rd_en,
  output logic [6:0]  fm_rd_addr,
  input  logic        fm_rd_gnt,
  output logic        trans_start,
  output logic        agg_start,
  output logic        amax_start,
  input  logic        trans_done,
  input  logic        agg_done,
  input  logic        amax_done,
  output logic        out_valid,
  output logic [2:0]  out_addr,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] cyc_cnt
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_LD_COO = 4'd1;
  localparam logic [3:0] S_LD_W   = 4'd2;
  localparam logic [3:0] S_LD_F   = 4'd3;
  localparam logic [3:0] S_XFORM  = 4'd4;
  localparam logic [3:0] S_AGG    = 4'd5;
  localparam logic [3:0] S_AMAX   = 4'd6;
  localparam logic [3:0] S_DRAIN  = 4'd7;
  localparam logic [3:0] S_FIN    = 4'd8;

  localparam logic [1:0] W_LAST  = 2'(NUM_CLASSES - 1);
  localparam logic [6:0] F_LAST  = 7'(NUM_FEAT - 1);
  localparam logic [2:0] N_LAST  = 3'(NUM_NODES - 1);
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYC - 1);

  logic [3:0]  state;
  logic [1:0]  wm_addr;
  logic [6:0]  fm_addr;
  logic [2:0]  nd_addr;
  logic [7:0]  wd;
  logic [15:0] cnt;
  logic        err_q;
  logic        phase_done;
  logic [3:0]  phase_nxt;

  // wd==0 marks the entry cycle of a compute phase; done is ignored there
  assign phase_done = ((state == S_XFORM) & trans_done) |
                      ((state == S_AGG)   & agg_done)   |
                      ((state == S_AMAX)  & amax_done);

  assign phase_nxt = (state == S_XFORM) ? S_AGG :
                     (state == S_AGG)   ? S_AMAX : S_DRAIN;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      wm_addr <= '0;
      fm_addr <= '0;
      nd_addr <= '0;
      wd      <= '0;
      cnt     <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (state != S_IDLE && cnt != 16'hFFFF)
        cnt <= cnt + 16'd1;
      if (state == S_IDLE) begin
        if (start && !abort) begin
          state   <= S_LD_COO;
          cnt     <= '0;
          wm_addr <= '0;
          fm_addr <= '0;
          nd_addr <= '0;
          wd      <= '0;
        end
      end else if (abort) begin
        state   <= S_IDLE;
        wm_addr <= '0;
        fm_addr <= '0;
        nd_addr <= '0;
        wd      <= '0;
      end else begin
        unique case (state)
          S_LD_COO: state <= S_LD_W;
          S_LD_W: begin
            if (wm_rd_gnt) begin
              if (wm_addr == W_LAST) begin
                wm_addr <= '0;
                state   <= S_LD_F;
              end else begin
                wm_addr <= wm_addr + 2'd1;
              end
            end
          end
          S_LD_F: begin
            if (fm_rd_gnt) begin
              if (fm_addr == F_LAST) begin
                fm_addr <= '0;
                state   <= S_XFORM;
              end else begin
                fm_addr <= fm_addr + 7'd1;
              end
            end
          end
          S_XFORM, S_AGG, S_AMAX: begin
            wd <= wd + 8'd1;
            if (wd != '0 && phase_done) begin
              wd    <= '0;
              state <= phase_nxt;
            end else if (wd == WD_LAST) begin
              wd    <= '0;
              err_q <= 1'b1;
              state <= S_IDLE;
            end
          end
          S_DRAIN: begin
            if (out_ready) begin
              if (nd_addr == N_LAST) begin
                nd_addr <= '0;
                state   <= S_FIN;
              end else begin
                nd_addr <= nd_addr + 3'd1;
              end
            end
          end
          S_FIN:   state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign coo_load_en = (state == S_LD_COO);
  assign wm_rd_en    = (state == S_LD_W);
  assign wm_rd_addr  = wm_addr;
  assign fm_rd_en    = (state == S_LD_F);
  assign fm_rd_addr  = fm_addr;
  assign trans_start = (state == S_XFORM) && (wd == '0);
  assign agg_start   = (state == S_AGG) && (wd == '0);
  assign amax_start  = (state == S_AMAX) && (wd == '0);
  assign out_valid   = (state == S_DRAIN);
  assign out_addr    = nd_addr;
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_FIN);
  assign err         = err_q;
  assign cyc_cnt     = cnt;

endmodule

// File: tb/tb_gcn_sched_ctrl.sv
// Scoreboard bench for gcn_sched_ctrl: a time-walk model predicts every
// handshake/strobe with its cycle; a negedge monitor pops and compares.
module tb_gcn_sched_ctrl;

  localparam int NN = 6;
  localparam int NC = 3;
  localparam int NF = 96;
  localparam int TO = 64;
  localparam int MAXC = 2048;

  localparam int K_COO = 0;
  localparam int K_W = 1;
  localparam int K_F = 2;
  localparam int K_TS = 3;
  localparam int K_OUT = 6;
  localparam int K_DONE = 7;
  localparam int K_ERR = 8;

  typedef struct {
    int kind;
    int val;
    int at;
  } ev_t;

  typedef struct {
    int gmode;
    int tdly;
    int adly;
    int mdly;
    bit spur;
    int ab;
    int rst;
    bit sbusy;
  } cfg_t;

  logic clk = 0;
  logic rst_n = 0;
  logic start = 0, abort = 0;
  logic wm_rd_gnt = 0, fm_rd_gnt = 0, out_ready = 0;
  logic trans_done = 0, agg_done = 0, amax_done = 0;
  logic coo_load_en, wm_rd_en, fm_rd_en, out_valid;
  logic [1:0] wm_rd_addr;
  logic [6:0] fm_rd_addr;
  logic [2:0] out_addr;
  logic trans_start, agg_start, amax_start;
  logic busy, done, err;
  logic [15:0] cyc_cnt;

  gcn_sched_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .coo_load_en(coo_load_en),
    .wm_rd_en(wm_rd_en), .wm_rd_addr(wm_rd_addr), .wm_rd_gnt(wm_rd_gnt),
    .fm_rd_en(fm_rd_en), .fm_rd_addr(fm_rd_addr), .fm_rd_gnt(fm_rd_gnt),
    .trans_start(trans_start), .agg_start(agg_start),
    .amax_start(amax_start),
    .trans_done(trans_done), .agg_done(agg_done), .amax_done(amax_done),
    .out_valid(out_valid), .out_addr(out_addr), .out_ready(out_ready),
    .busy(busy), .done(done), .err(err), .cyc_cnt(cyc_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  ev_t exp_q[$];

  bit wg[MAXC], fg[MAXC], rd[MAXC];
  bit td[MAXC], adn[MAXC], mdn[MAXC], sb[MAXC];
  int base, last_k, ab_k, rst_k;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic obs(input int k, input int v);
    ev_t e;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected event kind=%0d val=%0d at cycle %0d",
               k, v, cyc);
    end else begin
      e = exp_q.pop_front();
      if (k != e.kind || v != e.val || cyc != e.at) begin
        n_fail++;
        $display("FAIL event: got kind=%0d val=%0d cyc=%0d expected kind=%0d val=%0d cyc=%0d",
                 k, v, cyc, e.kind, e.val, e.at);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (coo_load_en) obs(K_COO, 0);
      if (wm_rd_en && wm_rd_gnt) obs(K_W, int'(wm_rd_addr));
      if (fm_rd_en && fm_rd_gnt) obs(K_F, int'(fm_rd_addr));
      if (trans_start) obs(K_TS, 0);
      if (agg_start) obs(K_TS + 1, 0);
      if (amax_start) obs(K_TS + 2, 0);
      if (out_valid && out_ready) obs(K_OUT, int'(out_addr));
      if (done) obs(K_DONE, 0);
      if (err) obs(K_ERR, 0);
    end
  end

  function automatic cfg_t mk(int g, int t, int a, int m, bit s,
                              int ab, int rs, bit sbz);
    cfg_t c;
    c.gmode = g; c.tdly = t; c.adly = a; c.mdly = m;
    c.spur = s; c.ab = ab; c.rst = rs; c.sbusy = sbz;
    return c;
  endfunction

  // Walk the run phase by phase in relative cycles; t is the cycle in which
  // the event is visible. A phase delay of 0 means its done never arrives.
  task automatic plan(input cfg_t c);
    ev_t evs[$];
    ev_t e;
    int t, tp, dl[3];
    bit dead;
    for (int i = 0; i < MAXC; i++) begin
      if (c.gmode == 0) begin
        wg[i] = 1; fg[i] = 1; rd[i] = 1;
      end else if (c.gmode == 1) begin
        wg[i] = (i >= 1500) || ($urandom_range(3, 0) != 0);
        fg[i] = (i >= 1500) || ($urandom_range(3, 0) != 0);
        rd[i] = (i >= 1500) || ($urandom_range(3, 0) != 0);
      end else begin
        wg[i] = !(i >= 3 && i <= 5);
        fg[i] = 1;
        rd[i] = (i % 2 == 0);
      end
      td[i] = 0; adn[i] = 0; mdn[i] = 0;
      sb[i] = c.sbusy && ($urandom_range(7, 0) == 0);
    end
    dl[0] = c.tdly; dl[1] = c.adly; dl[2] = c.mdly;
    dead = 0;
    evs.push_back('{K_COO, 0, 1});
    t = 2;
    for (int a = 0; a < NC; a++) begin
      while (!wg[t]) t++;
      evs.push_back('{K_W, a, t});
      t++;
    end
    for (int a = 0; a < NF; a++) begin
      while (!fg[t]) t++;
      evs.push_back('{K_F, a, t});
      t++;
    end
    for (int p = 0; p < 3; p++) begin
      if (!dead) begin
        tp = t;
        evs.push_back('{K_TS + p, 0, tp});
        if (p == 0 && c.spur) td[tp] = 1;
        if (dl[p] == 0) begin
          evs.push_back('{K_ERR, 0, tp + TO});
          last_k = tp + TO - 1;
          dead = 1;
        end else begin
          if (p == 0) td[tp + dl[p]] = 1;
          if (p == 1) adn[tp + dl[p]] = 1;
          if (p == 2) mdn[tp + dl[p]] = 1;
          t = tp + dl[p] + 1;
        end
      end
    end
    if (!dead) begin
      for (int a = 0; a < NN; a++) begin
        while (!rd[t]) t++;
        evs.push_back('{K_OUT, a, t});
        t++;
      end
      evs.push_back('{K_DONE, 0, t});
      last_k = t;
    end
    ab_k = (c.ab == -2) ? int'($urandom_range(last_k - 1, 1)) : c.ab;
    rst_k = c.rst;
    foreach (evs[i]) begin
      e = evs[i];
      if ((ab_k < 0 || e.at <= ab_k) && (rst_k < 0 || e.at < rst_k)) begin
        e.at = e.at + base;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic run(input cfg_t c);
    int lim, expc, bend;
    base = cyc;
    plan(c);
    bend = (ab_k >= 0) ? ab_k : last_k;
    expc = (rst_k >= 0) ? 0 : bend;
    lim = ((rst_k >= 0) ? rst_k : bend) + 3;
    start = 1; abort = 0;
    for (int k = 1; k <= lim; k++) begin
      @(posedge clk); #1;
      start = sb[k] && (k <= bend) && (rst_k < 0 || k < rst_k);
      wm_rd_gnt = wg[k]; fm_rd_gnt = fg[k]; out_ready = rd[k];
      trans_done = td[k]; agg_done = adn[k]; amax_done = mdn[k];
      abort = (ab_k >= 0 && k == ab_k);
      if (ab_k >= 0 && k == ab_k + 1) begin
        check("abort_busy", busy, 0);
        check("abort_reqs", {wm_rd_en, fm_rd_en, out_valid, done, err}, 0);
      end
      if (rst_k >= 0 && k == rst_k + 1) rst_n = 1;
      if (rst_k >= 0 && k == rst_k) begin
        #1 rst_n = 0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_strobes", {coo_load_en, wm_rd_en, fm_rd_en, trans_start,
              agg_start, amax_start, out_valid, done, err}, 0);
        check("rst_addr", {wm_rd_addr, fm_rd_addr, out_addr}, 0);
        check("rst_cyc", cyc_cnt, 0);
      end
    end
    start = 0; abort = 0;
    wm_rd_gnt = 0; fm_rd_gnt = 0; out_ready = 0;
    trans_done = 0; agg_done = 0; amax_done = 0;
    @(posedge clk); #1;
    check("leftover_events", exp_q.size(), 0);
    check("idle_busy", busy, 0);
    check("cyc_cnt", cyc_cnt, expc);
    exp_q.delete();
  endtask

  initial begin
    int d[3];
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_strobes", {coo_load_en, wm_rd_en, fm_rd_en, trans_start,
          agg_start, amax_start, out_valid, done, err}, 0);
    check("reset_cyc", cyc_cnt, 0);
    rst_n = 1;
    @(posedge clk); #1;

    run(mk(0, 1, 1, 1, 0, -1, -1, 0));
    run(mk(2, 1, 1, 1, 0, -1, -1, 0));
    run(mk(0, 1, 0, 1, 0, -1, -1, 0));
    run(mk(0, 1, 1, 1, 0, -1, -1, 0));
    run(mk(0, 5, 3, 63, 1, -1, -1, 0));
    run(mk(0, 1, 1, 1, 0, 45, -1, 1));

    start = 1; abort = 1;
    @(posedge clk); #1;
    start = 0; abort = 0;
    check("idle_abort_busy", busy, 0);
    check("idle_abort_coo", coo_load_en, 0);
    @(posedge clk); #1;
    check("idle_abort_busy2", busy, 0);

    run(mk(0, 1, 1, 1, 0, -1, 110, 0));
    run(mk(0, 1, 1, 1, 0, -1, -1, 0));

    for (int r = 0; r < 8; r++) begin
      for (int p = 0; p < 3; p++)
        d[p] = ($urandom_range(9, 0) == 0) ? 0 : int'($urandom_range(63, 1));
      run(mk(1, d[0], d[1], d[2], 1'($urandom_range(1, 0)),
             ($urandom_range(3, 0) == 0) ? -2 : -1, -1,
             1'($urandom_range(1, 0))));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
